// File: rtl/grid_pkg.sv
// Shared constants, state encoding and coordinate helpers
// for the drawing-grid plot scheduler.
package grid_pkg;

  localparam int GRID_SIZE  = 28;
  localparam int CELL_COUNT = GRID_SIZE * GRID_SIZE;
  localparam int CHUNK      = 4;
  localparam int OFFSET_X   = 24;
  localparam int OFFSET_Y   = 4;
  localparam int CUR_INIT   = 14;

  localparam logic [2:0] COL_BLACK     = 3'b000;
  localparam logic [2:0] COL_WHITE     = 3'b111;
  localparam logic [2:0] CURSOR_COLOUR = 3'b100;

  typedef enum logic [2:0] {
    INIT_CLEAR,
    IDLE,
    PAINT,
    CLEAR,
    CUR_OLD,
    CUR_NEW
  } state_t;

  function automatic logic [9:0] cell_addr(
    input logic [4:0] x,
    input logic [4:0] y
  );
    return 10'(y) * 10'(GRID_SIZE) + 10'(x);
  endfunction

  function automatic logic [7:0] fb_x(input logic [4:0] x);
    return 8'(OFFSET_X) + 8'(x) * 8'(CHUNK);
  endfunction

  function automatic logic [6:0] fb_y(input logic [4:0] y);
    return 7'(OFFSET_Y) + 7'(y) * 7'(CHUNK);
  endfunction

  function automatic logic in_grid(
    input logic [4:0] x,
    input logic [4:0] y
  );
    return (x < 5'(GRID_SIZE)) && (y < 5'(GRID_SIZE));
  endfunction

endpackage

// File: rtl/chunk_scanner.sv
// Expands one cell into a CHUNK x CHUNK plot burst, dx fastest.
// A start on the done cycle chains bursts with no idle gap.
module chunk_scanner
  import grid_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       done
);

  localparam int DW = $clog2(CHUNK);
  localparam logic [DW-1:0] LAST = DW'(CHUNK - 1);

  logic          active_q, active_d;
  logic [DW-1:0] dx_q, dx_d;
  logic [DW-1:0] dy_q, dy_d;
  logic [7:0]    bx_q, bx_d;
  logic [6:0]    by_q, by_d;
  logic [2:0]    col_q, col_d;

  assign done       = active_q && (dx_q == LAST) && (dy_q == LAST);
  assign plot       = active_q;
  assign vga_x      = bx_q + 8'(dx_q);
  assign vga_y      = by_q + 7'(dy_q);
  assign vga_colour = col_q;

  always_comb begin
    active_d = active_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    bx_d     = bx_q;
    by_d     = by_q;
    col_d    = col_q;
    if (start) begin
      active_d = 1'b1;
      dx_d     = '0;
      dy_d     = '0;
      bx_d     = base_x;
      by_d     = base_y;
      col_d    = colour;
    end else if (done) begin
      active_d = 1'b0;
    end else if (active_q) begin
      dx_d = (dx_q == LAST) ? '0 : dx_q + 1'b1;
      if (dx_q == LAST) dy_d = dy_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      col_q    <= '0;
    end else begin
      active_q <= active_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      col_q    <= col_d;
    end
  end

endmodule

// File: rtl/grid_plot_scheduler.sv
// Owns the 28x28 drawing grid and arbitrates clear, paint and
// cursor redraws into the single framebuffer plot port.
module grid_plot_scheduler
  import grid_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear_req,
  output logic       clear_ack,
  input  logic       paint_req,
  input  logic [4:0] paint_x,
  input  logic [4:0] paint_y,
  input  logic       paint_val,
  output logic       paint_ack,
  input  logic [4:0] cur_x,
  input  logic [4:0] cur_y,
  output logic       busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  input  logic [9:0] rd_addr,
  output logic       rd_data
);

  state_t     state_q, state_d;
  logic [4:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [4:0] new_x_q, new_x_d, new_y_q, new_y_d;
  logic [4:0] cx_q, cx_d, cy_q, cy_d;
  logic       launched_q, launched_d;
  logic       busy_q, busy_d;
  logic       rd_data_q, rd_data_d;

  logic [CELL_COUNT-1:0] grid_q;
  logic       we, wdata, launch;
  logic [9:0] waddr, prev_addr;
  logic       sc_start, sc_plot, sc_done;
  logic [7:0] sc_x;
  logic [6:0] sc_y;
  logic [2:0] sc_col;
  logic       cur_move, clear_go, paint_go, cur_go, prev_bit;

  chunk_scanner u_scan (
    .clock      (clock),
    .resetn     (resetn),
    .start      (sc_start),
    .base_x     (sc_x),
    .base_y     (sc_y),
    .colour     (sc_col),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (sc_plot),
    .done       (sc_done)
  );

  assign vga_plot  = sc_plot;
  assign busy      = busy_q;
  assign rd_data   = rd_data_q;
  assign prev_addr = cell_addr(prev_x_q, prev_y_q);
  assign prev_bit  = grid_q[prev_addr];
  assign cur_move  = in_grid(cur_x, cur_y) &&
                     ((cur_x != prev_x_q) || (cur_y != prev_y_q));
  assign clear_go  = clear_req;
  assign paint_go  = paint_req && !clear_req;
  assign cur_go    = cur_move && !clear_req && !paint_req;

  always_comb begin
    state_d    = state_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    new_x_d    = new_x_q;
    new_y_d    = new_y_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    launched_d = launched_q;
    clear_ack  = 1'b0;
    paint_ack  = 1'b0;
    sc_start   = 1'b0;
    sc_x       = fb_x(cx_q);
    sc_y       = fb_y(cy_q);
    sc_col     = COL_BLACK;
    we         = 1'b0;
    waddr      = cell_addr(cx_q, cy_q);
    wdata      = 1'b0;
    launch     = 1'b0;
    unique case (state_q)
      INIT_CLEAR, CLEAR: begin
        if (!launched_q && (!sc_plot || sc_done)) launch = 1'b1;
        else if (launched_q && sc_done) state_d = IDLE;
      end
      IDLE: begin
        unique case (1'b1)
          clear_go: begin
            clear_ack  = 1'b1;
            launched_d = 1'b0;
            launch     = 1'b1;
            state_d    = CLEAR;
          end
          paint_go: begin
            paint_ack = 1'b1;
            if (in_grid(paint_x, paint_y)) begin
              we       = 1'b1;
              waddr    = cell_addr(paint_x, paint_y);
              wdata    = paint_val;
              sc_start = 1'b1;
              sc_x     = fb_x(paint_x);
              sc_y     = fb_y(paint_y);
              if (paint_x == prev_x_q && paint_y == prev_y_q)
                sc_col = CURSOR_COLOUR;
              else
                sc_col = paint_val ? COL_WHITE : COL_BLACK;
              state_d  = PAINT;
            end
          end
          cur_go: begin
            new_x_d  = cur_x;
            new_y_d  = cur_y;
            sc_start = 1'b1;
            sc_x     = fb_x(prev_x_q);
            sc_y     = fb_y(prev_y_q);
            sc_col   = prev_bit ? COL_WHITE : COL_BLACK;
            state_d  = CUR_OLD;
          end
          default: ;
        endcase
      end
      PAINT: if (sc_done) state_d = IDLE;
      CUR_OLD: begin
        if (sc_done) begin
          sc_start = 1'b1;
          sc_x     = fb_x(new_x_q);
          sc_y     = fb_y(new_y_q);
          sc_col   = CURSOR_COLOUR;
          state_d  = CUR_NEW;
        end
      end
      CUR_NEW: begin
        if (sc_done) begin
          prev_x_d = new_x_q;
          prev_y_d = new_y_q;
          state_d  = IDLE;
        end
      end
      default: state_d = INIT_CLEAR;
    endcase
    // clear sweep: zero the cell and chain its burst
    if (launch) begin
      sc_start = 1'b1;
      we       = 1'b1;
      if (cx_q == prev_x_q && cy_q == prev_y_q)
        sc_col = CURSOR_COLOUR;
      if (cx_q == 5'(GRID_SIZE - 1)) begin
        cx_d = '0;
        if (cy_q == 5'(GRID_SIZE - 1)) begin
          cy_d       = '0;
          launched_d = 1'b1;
        end else begin
          cy_d = cy_q + 1'b1;
        end
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
    busy_d    = (state_d != IDLE);
    rd_data_d = (rd_addr < 10'(CELL_COUNT)) ? grid_q[rd_addr] : 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT_CLEAR;
      prev_x_q   <= 5'(CUR_INIT);
      prev_y_q   <= 5'(CUR_INIT);
      new_x_q    <= '0;
      new_y_q    <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      launched_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      new_x_q    <= new_x_d;
      new_y_q    <= new_y_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      launched_q <= launched_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // grid contents are zeroed by the clear sweep, not by reset
  always_ff @(posedge clock) begin
    if (we) grid_q[waddr] <= wdata;
  end

endmodule

// File: tb/tb_grid_plot_scheduler.sv
// Scoreboard bench: driver pushes expected plots, monitor pops
// and compares on every vga_plot cycle.
module tb_grid_plot_scheduler;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       clear_req = 1'b0, clear_ack;
  logic       paint_req = 1'b0, paint_ack;
  logic [4:0] paint_x = '0, paint_y = '0;
  logic       paint_val = 1'b0;
  logic [4:0] cur_x = 5'd14, cur_y = 5'd14;
  logic       busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [9:0] rd_addr = '0;
  logic       rd_data;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  plot_t expq[$];
  plot_t mon_e;
  int    tests = 0;
  int    fails = 0;
  int    plots_seen = 0;
  bit    mgrid[784];
  int    px = 14, py = 14;

  always #5 clock = ~clock;

  grid_plot_scheduler dut (
    .clock      (clock),
    .resetn     (resetn),
    .clear_req  (clear_req),
    .clear_ack  (clear_ack),
    .paint_req  (paint_req),
    .paint_x    (paint_x),
    .paint_y    (paint_y),
    .paint_val  (paint_val),
    .paint_ack  (paint_ack),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (resetn && vga_plot) begin
      plots_seen++;
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d expected none",
                 vga_x, vga_y, vga_colour);
      end else begin
        mon_e = expq.pop_front();
        if ({vga_x, vga_y, vga_colour} != mon_e) begin
          fails++;
          $display("FAIL plot: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   vga_x, vga_y, vga_colour, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  task automatic push_cell(input int x, input int y, input logic [2:0] c);
    plot_t p;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) begin
        p.x = 8'(24 + 4 * x + dx);
        p.y = 7'(4 + 4 * y + dy);
        p.c = c;
        expq.push_back(p);
      end
  endtask

  task automatic push_clear();
    for (int y = 0; y < 28; y++)
      for (int x = 0; x < 28; x++) begin
        mgrid[y * 28 + x] = 1'b0;
        push_cell(x, y, (x == px && y == py) ? 3'b100 : 3'b000);
      end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy || expq.size() != 0) && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk({name, "_timeout"}, int'(n >= budget), 0);
    chk({name, "_drained"}, expq.size(), 0);
  endtask

  task automatic do_reset();
    int base;
    resetn = 1'b0;
    clear_req = 1'b0;
    paint_req = 1'b0;
    cur_x = 5'd14;
    cur_y = 5'd14;
    expq.delete();
    px = 14;
    py = 14;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_acks", {clear_ack, paint_ack}, 0);
    chk("rst_coord", {vga_x, vga_y, vga_colour}, 0);
    chk("rst_rd", rd_data, 0);
    push_clear();
    base = plots_seen;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("init_busy", busy, 1);
    wait_done("init_clear", 14000);
    chk("init_plot_count", plots_seen - base, 12544);
  endtask

  task automatic paint_op(input int x, input int y, input bit v);
    bit ok;
    ok = (x < 28) && (y < 28);
    @(negedge clock);
    paint_x = 5'(x);
    paint_y = 5'(y);
    paint_val = v;
    paint_req = 1'b1;
    #1;
    chk("paint_ack", paint_ack, 1);
    if (ok) begin
      push_cell(x, y, (x == px && y == py) ? 3'b100 : (v ? 3'b111 : 3'b000));
      mgrid[y * 28 + x] = v;
    end
    @(posedge clock);
    #1;
    paint_req = 1'b0;
    chk("paint_busy", busy, int'(ok));
  endtask

  task automatic cursor_set(input int nx, input int ny);
    @(negedge clock);
    cur_x = 5'(nx);
    cur_y = 5'(ny);
    push_cell(px, py, mgrid[py * 28 + px] ? 3'b111 : 3'b000);
    push_cell(nx, ny, 3'b100);
    px = nx;
    py = ny;
  endtask

  task automatic read_chk(input int addr);
    @(negedge clock);
    rd_addr = 10'(addr);
    @(posedge clock);
    #1;
    chk("rd_data", rd_data, (addr < 784) ? int'(mgrid[addr]) : 0);
  endtask

  initial begin
    int base, n, op, nx, ny;
    do_reset();
    for (int a = 0; a < 784; a++) read_chk(a);

    paint_op(3, 5, 1);
    wait_done("paint_3_5", 100);
    read_chk(143);

    base = plots_seen;
    paint_op(28, 0, 1);
    repeat (20) @(negedge clock);
    #1;
    chk("oor_paint_plots", plots_seen - base, 0);
    read_chk(28);

    cursor_set(15, 14);
    @(posedge clock);
    #1;
    chk("cursor_busy", busy, 1);
    wait_done("cursor_15_14", 100);

    // overwrite a set cell while reading it on the accept edge
    @(negedge clock);
    rd_addr = 10'd143;
    paint_op(3, 5, 0);
    chk("rd_old_value", rd_data, 1);
    wait_done("repaint", 100);
    read_chk(143);
    read_chk(1000);

    @(negedge clock);
    clear_req = 1'b1;
    paint_req = 1'b1;
    paint_x = 5'd2;
    paint_y = 5'd2;
    paint_val = 1'b1;
    #1;
    chk("prio_clear_ack", clear_ack, 1);
    chk("prio_paint_ack", paint_ack, 0);
    push_clear();
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    chk("clear_ack_pulse", clear_ack, 0);
    n = 0;
    while (!paint_ack && n < 14000) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("deferred_paint_timeout", int'(n >= 14000), 0);
    chk("deferred_paint_after_clear", expq.size(), 0);
    chk("deferred_paint_idle", busy, 0);
    push_cell(2, 2, 3'b111);
    mgrid[2 * 28 + 2] = 1'b1;
    @(posedge clock);
    #1;
    paint_req = 1'b0;
    wait_done("deferred_paint", 100);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          paint_op($urandom_range(0, 30), $urandom_range(0, 30),
                   1'($urandom_range(0, 1)));
          wait_done("rand_paint", 100);
        end
        1, 2: begin
          if (op == 2)
            paint_op($urandom_range(0, 29), $urandom_range(0, 29),
                     1'($urandom_range(0, 1)));
          do begin
            nx = $urandom_range(0, 27);
            ny = $urandom_range(0, 27);
          end while (nx == px && ny == py);
          cursor_set(nx, ny);
          wait_done("rand_cursor", 200);
        end
        3: begin
          base = plots_seen;
          @(negedge clock);
          cur_x = 5'($urandom_range(28, 31));
          cur_y = 5'($urandom_range(0, 31));
          repeat (5) @(negedge clock);
          #1;
          chk("oor_cursor_busy", busy, 0);
          chk("oor_cursor_plots", plots_seen - base, 0);
          cur_x = 5'(px);
          cur_y = 5'(py);
        end
        default: read_chk($urandom_range(0, 1023));
      endcase
    end

    base = plots_seen;
    paint_op(10, 10, 1);
    n = 0;
    while (plots_seen < base + 8 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("mid_reset_timeout", int'(n >= 100), 0);
    resetn = 1'b0;
    #1;
    chk("mid_reset_plot", vga_plot, 0);
    chk("mid_reset_busy", busy, 0);
    do_reset();
    read_chk(10 * 28 + 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
